// File: rtl/and_gate_response_checker_pkg.sv
// Shared types and MISR helper for the AND-gate BIST response checker (package and_bist_pkg).
package and_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    localparam logic [7:0]  MISR_POLY_DEF = 8'h1D;
    localparam logic [7:0]  MISR_SEED_DEF = 8'hFF;
    localparam int unsigned MISR_MAX_W    = 32;

    // Computed at the widest supported width; callers truncate to their own MISR_W.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [MISR_MAX_W-1:0] data,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] fb;
        mask = (w >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
        fb   = (((sig >> (w - 1)) & MISR_MAX_W'(1)) != '0) ? poly : '0;
        return ((sig << 1) ^ fb ^ data) & mask;
    endfunction

endpackage

// File: rtl/and_gate_response_checker_misr.sv
// Multiple-input signature register: synchronous seed load, compaction when enabled.
module misr_reg
    import and_bist_pkg::*;
#(
    parameter int unsigned           MISR_W    = 8,
    parameter logic [MISR_W-1:0]     MISR_POLY = MISR_W'(MISR_POLY_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [MISR_W-1:0] load_val,
    input  logic              en,
    input  logic [MISR_W-1:0] data,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] nxt;

    always_comb begin
        nxt = MISR_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(MISR_POLY),
                                MISR_MAX_W'(data), MISR_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= load_val;
        end else if (en) begin
            sig <= nxt;
        end
    end

endmodule

// File: rtl/and_gate_response_checker.sv
// MISR-based response checker for the 3-input AND gate BIST.
// Optional reference check of output d against a&b&c: define AND_REF_CHECK_EN.
module and_gate_response_checker
    import and_bist_pkg::*;
#(
    parameter int unsigned       IN_W       = 3,
    parameter int unsigned       OUT_W      = 2,
    parameter int unsigned       N_VEC      = 8,
    parameter int unsigned       MISR_W     = 8,
    parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(MISR_POLY_DEF),
    parameter logic [MISR_W-1:0] MISR_SEED  = MISR_W'(MISR_SEED_DEF),
    parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stim_valid,
    input  logic [IN_W-1:0]            stim,
    input  logic [OUT_W-1:0]           resp,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [MISR_W-1:0]          signature,
    output logic [$clog2(N_VEC+1)-1:0] vec_cnt
`ifdef AND_REF_CHECK_EN
    ,
    output logic [$clog2(N_VEC+1)-1:0] mismatch_cnt
`endif
);

    localparam int unsigned    CW       = $clog2(N_VEC + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(N_VEC - 1);

    state_t            state_q, state_d;
    logic              load;
    logic              accept;
    logic              last;
    logic              match;
    logic [MISR_W-1:0] vec_data;
    logic [MISR_W-1:0] sig_next;

    always_comb begin
        vec_data = '0;
        vec_data[IN_W+OUT_W-1:0] = {stim, resp};
    end

    assign accept = (state_q == COLLECT) && stim_valid;
    assign last   = accept && (vec_cnt == LAST_IDX);
    assign busy   = (state_q == COLLECT);
    assign done   = (state_q == DONE);

    // Same next value the MISR will register, so pass is judged on the final signature.
    always_comb begin
        sig_next = MISR_W'(misr_next(MISR_MAX_W'(signature), MISR_MAX_W'(MISR_POLY),
                                     MISR_MAX_W'(vec_data), MISR_W));
    end

`ifdef AND_REF_CHECK_EN
    logic          ref_miss;
    logic [CW-1:0] mismatch_next;

    assign ref_miss      = resp[OUT_W-1] != (&stim);
    assign mismatch_next = mismatch_cnt + CW'(accept && ref_miss);
    assign match         = (sig_next == GOLDEN_SIG) && (mismatch_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt <= '0;
        end else if (load) begin
            mismatch_cnt <= '0;
        end else begin
            mismatch_cnt <= mismatch_next;
        end
    end
`else
    assign match = (sig_next == GOLDEN_SIG);
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    load    = 1'b1;
                end
            end
            COLLECT: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                vec_cnt <= '0;
                pass    <= 1'b0;
            end else if (accept) begin
                vec_cnt <= vec_cnt + CW'(1);
                if (last) begin
                    pass <= match;
                end
            end
        end
    end

    misr_reg #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (MISR_SEED),
        .en       (accept),
        .data     (vec_data),
        .sig      (signature)
    );

endmodule

// File: tb/tb_and_gate_response_checker.sv
// Directed bench for and_gate_response_checker; expected signatures hand-computed.
module tb_and_gate_response_checker;

`ifdef AND_REF_CHECK_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stim_valid;
    logic [2:0] stim;
    logic [1:0] resp;
    logic [1:0] resp_f;

    logic       a_busy, a_done, a_pass;
    logic [7:0] a_sig;
    logic [0:0] a_vec;
    logic       b_busy, b_done, b_pass;
    logic [7:0] b_sig;
    logic [0:0] b_vec;
    logic       e_busy, e_done, e_pass;
    logic [7:0] e_sig;
    logic [3:0] e_vec;
    logic       f_busy, f_done, f_pass;
    logic [7:0] f_sig;
    logic [3:0] f_vec;
`ifdef AND_REF_CHECK_EN
    logic [0:0] a_mis, b_mis;
    logic [3:0] e_mis, f_mis;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Faulty DUT variant: d and e both stuck low when a=b=c=1.
    assign resp_f = (stim == 3'b111) ? 2'b00 : resp;

    and_gate_response_checker #(.N_VEC(1), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h1D)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stim_valid(stim_valid), .stim(stim), .resp(resp),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .vec_cnt(a_vec)
`ifdef AND_REF_CHECK_EN
        , .mismatch_cnt(a_mis)
`endif
    );

    and_gate_response_checker #(.N_VEC(1), .MISR_SEED(8'hFF), .GOLDEN_SIG(8'h1D)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stim_valid(stim_valid), .stim(stim), .resp(resp),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .vec_cnt(b_vec)
`ifdef AND_REF_CHECK_EN
        , .mismatch_cnt(b_mis)
`endif
    );

    and_gate_response_checker #(.N_VEC(8), .GOLDEN_SIG(8'h04)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .stim_valid(stim_valid), .stim(stim), .resp(resp),
        .busy(e_busy), .done(e_done), .pass(e_pass), .signature(e_sig), .vec_cnt(e_vec)
`ifdef AND_REF_CHECK_EN
        , .mismatch_cnt(e_mis)
`endif
    );

    and_gate_response_checker #(.N_VEC(8), .GOLDEN_SIG(8'h06)) dut_f (
        .clk(clk), .rst_n(rst_n), .start(start), .stim_valid(stim_valid), .stim(stim), .resp(resp_f),
        .busy(f_busy), .done(f_done), .pass(f_pass), .signature(f_sig), .vec_cnt(f_vec)
`ifdef AND_REF_CHECK_EN
        , .mismatch_cnt(f_mis)
`endif
    );

    function automatic logic [1:0] good_resp(input logic [2:0] s);
        return {&s, ~(&s)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input int unsigned v);
        stim       = 3'(v);
        resp       = good_resp(3'(v));
        stim_valid = 1'b1;
        tick();
        stim_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stim_valid = 1'b0; stim = '0; resp = '0;
        repeat (2) tick();
        check("rst_busy", e_busy, 0);
        check("rst_done", e_done, 0);
        check("rst_pass", e_pass, 0);
        check("rst_sig", e_sig, 0);
        check("rst_vec", e_vec, 0);
        rst_n = 1'b1;
        tick();

        // Single-vector runs; valid coinciding with start must be ignored
        start = 1'b1; stim_valid = 1'b1; stim = 3'b111; resp = 2'b01;
        tick();
        start = 1'b0;
        check("a_busy", a_busy, 1);
        check("a_done_early", a_done, 0);
        check("a_seed", a_sig, 8'h00);
        check("a_vec0", a_vec, 0);
        check("b_seed", b_sig, 8'hFF);
        tick();
        stim_valid = 1'b0;
        check("a_done", a_done, 1);
        check("a_busy_off", a_busy, 0);
        check("a_sig", a_sig, 8'h1D);
        check("a_vec1", a_vec, 1);
        check("a_pass", a_pass, REF_EN ? 0 : 1);
        check("b_sig", b_sig, 8'hFE);
        check("b_done", b_done, 1);
        check("b_pass", b_pass, 0);
        tick();
        check("a_done_hold", a_done, 1);
        check("a_sig_hold", a_sig, 8'h1D);

        rst_n = 1'b0;
        #1;
        check("a_rst_done", a_done, 0);
        check("a_rst_sig", a_sig, 0);
        tick();
        rst_n = 1'b1;

        // Eight-vector run with stall and ignored start pulses
        start = 1'b1; stim_valid = 1'b1; stim = 3'd3; resp = good_resp(3'd3);
        tick();
        start = 1'b0; stim_valid = 1'b0;
        check("e_busy", e_busy, 1);
        check("e_seed", e_sig, 8'hFF);
        check("e_vec0", e_vec, 0);
        for (int i = 0; i < 4; i++) apply(i);
        check("e_vec4", e_vec, 4);
        check("e_sig4", e_sig, 8'h48);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("e_stall_vec", e_vec, 4);
        check("e_stall_sig", e_sig, 8'h48);
        check("e_stall_busy", e_busy, 1);
        for (int i = 4; i < 7; i++) apply(i);
        check("e_vec7", e_vec, 7);
        check("e_busy7", e_busy, 1);
        check("e_done7", e_done, 0);
        apply(7);
        check("e_busy8", e_busy, 0);
        check("e_done8", e_done, 1);
        check("e_vec8", e_vec, 8);
        check("e_sig8", e_sig, 8'h04);
        check("e_pass", e_pass, 1);
        check("f_sig", f_sig, 8'h06);
        check("f_pass", f_pass, REF_EN ? 0 : 1);
`ifdef AND_REF_CHECK_EN
        check("e_mis", e_mis, 0);
        check("f_mis", f_mis, 1);
`endif
        stim_valid = 1'b1; stim = 3'd5; resp = good_resp(3'd5);
        tick();
        tick();
        stim_valid = 1'b0;
        check("e_done_hold", e_done, 1);
        check("e_vec_hold", e_vec, 8);
        check("e_sig_hold", e_sig, 8'h04);
        check("e_pass_hold", e_pass, 1);

        // Restart from DONE, then asynchronous reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c_busy", e_busy, 1);
        check("c_done", e_done, 0);
        check("c_vec0", e_vec, 0);
        check("c_seed", e_sig, 8'hFF);
        for (int i = 0; i < 4; i++) apply(i);
        check("c_vec4", e_vec, 4);
        check("c_sig4", e_sig, 8'h48);
        #2;
        rst_n = 1'b0;
        #1;
        check("c_rst_busy", e_busy, 0);
        check("c_rst_done", e_done, 0);
        check("c_rst_pass", e_pass, 0);
        check("c_rst_sig", e_sig, 0);
        check("c_rst_vec", e_vec, 0);
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) apply(i);
        check("c_done", e_done, 1);
        check("c_vec8", e_vec, 8);
        check("c_sig8", e_sig, 8'h04);
        check("c_pass", e_pass, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/and_gate_response_checker.md
Name: and_gate_response_checker

Overview:
- Synthesizable response-side companion to the 3-input AND gate stimulus generator; that generator drives an exhaustive 3-bit count pattern into the DUT.
- This block observes each applied stimulus vector together with the DUT outputs (d, e) and compacts them into a MISR signature.
- After N_VEC vectors it compares the signature against a golden value and reports pass/fail.
- Sits beside the DUT in the on-board BIST wrapper; the result is shown on LEDs.

Parameters:
- IN_W, 3: stimulus width (a, b, c).
- OUT_W, 2: DUT response width (d, e).
- N_VEC, 8: vectors per run; must be ≥1.
- MISR_W, 8: signature width; must be ≥ IN_W+OUT_W.
- MISR_POLY, 8'h1D: feedback polynomial taps.
- MISR_SEED, 8'hFF: signature value loaded on start.
- GOLDEN_SIG, 8'h00: expected final signature; the integrator sets it per DUT.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run (pulse).
- stim_valid  in  1  stim/resp hold one valid vector this cycle.
- stim  in  IN_W  applied stimulus, bit order {a,b,c}.
- resp  in  OUT_W  DUT outputs, bit order {d,e}.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  result; meaningful only while done=1.
- signature  out  MISR_W  current MISR value.
- vec_cnt  out  $clog2(N_VEC+1)  vectors accepted in this run.

Behaviour:
- Reset values: busy=0, done=0, pass=0, signature=0, vec_cnt=0, state=IDLE.
- States and transitions:
  - IDLE: start → COLLECT. On that edge, signature←MISR_SEED and vec_cnt←0.
  - COLLECT: each cycle with stim_valid=1, signature←next and vec_cnt++.
    - next = (sig<<1) ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended {stim,resp}.
    - The accepted vector that makes vec_cnt==N_VEC moves the FSM to DONE on the same edge.
    - On that edge, pass←(next==GOLDEN_SIG).
  - DONE: done=1 and pass stable. start → COLLECT with the same re-initialisation as from IDLE.
- busy=1 exactly while in COLLECT. done=1 exactly while in DONE.
- Latency: done rises on the first clock edge after the last valid vector is presented.
- stim_valid in IDLE or DONE is ignored, including when it coincides with start. The first vector counts from the cycle after start.
- start during COLLECT is ignored; the run is not restarted.
- stim_valid low during COLLECT leaves signature and vec_cnt unchanged; the run waits indefinitely.
- rst_n asserted mid-run clears all state immediately. No partial result is reported.
- All arithmetic is unsigned and the MISR wraps modulo 2^MISR_W. vec_cnt cannot exceed N_VEC.

Optional Feature:
- Macro: AND_REF_CHECK_EN.
- Defined:
  - Adds output mismatch_cnt (width $clog2(N_VEC+1), reset 0, cleared on start).
  - mismatch_cnt increments on each accepted vector where resp[OUT_W-1] != &stim, i.e. d differs from a&b&c.
  - pass additionally requires mismatch_cnt==0 after the final vector is included.
- Undefined: the port and logic are absent; pass depends on the signature only.

Decomposition:
- Shared package and_bist_pkg:
  - state enum {IDLE, COLLECT, DONE};
  - default MISR_POLY and MISR_SEED constants;
  - a function computing the MISR next value.
- Natural sub-module misr_reg (parameters MISR_W, MISR_POLY):
  - inputs clk, rst_n, load, load_val, en, data;
  - output sig.
- Top level holds the FSM, the counters and the compare.

Test Plan:
- N_VEC=1, MISR_SEED=8'h00, start, then stim=3'b111, resp=2'b01, valid → signature=8'h1D, vec_cnt=1, done=1 next cycle; with GOLDEN_SIG=8'h1D, pass=1.
- Same vector with MISR_SEED=8'hFF → signature=8'hFE. With GOLDEN_SIG=8'h1D, pass=0 and done=1.
- N_VEC=8, the stimulus generator's 3'b000..3'b111 sequence with a correct DUT, valid deasserted for 3 cycles mid-run → vec_cnt=8, signature equals the bench model's value, busy drops exactly one cycle after the 8th vector.
- start asserted with stim_valid=1 in IDLE, and start pulsed again during COLLECT → the first vector is not counted, the run is not restarted, vec_cnt still reaches N_VEC.
- rst_n low after 4 of 8 vectors → all outputs 0 asynchronously. A new start then completes a full 8-vector run.
- AND_REF_CHECK_EN defined, resp d forced to 0 for stim=3'b111 → mismatch_cnt=1 and pass=0 even when GOLDEN_SIG matches the signature.
